pwm_deadtime_gate_stage: RTL and testbench
==========================================

// Module: pwm_deadtime_gate_stage
// PURPOSE
//  Output stage directly downstream of the quad PWM generator in the wrapped FET driver design.
//  - Converts each raw PWM channel into a complementary high-side/low-side gate pair.
//  - Inserts a programmable break-before-make dead time on every transition.
//  - Latches an external over-current fault and holds every gate low until software clears it.
//  - Its gate outputs feed the buffered io_out bits in the project wrapper.
// PARAMETERS
//  NCH          4   number of PWM channels / gate pairs
//  DT_W         8   width of dead-time count
//  FILT_CYCLES  4   consecutive fault samples required to latch (used only with FAULT_FILTER_EN)
// PORTS
//  wb_clk_i     in   1      system clock, all logic on rising edge
//  wb_rst_ni    in   1      synchronous reset, active-low
//  enable_i     in   1      global gate enable
//  pwm_i        in   NCH    raw PWM from generator, 1 = high side wanted
//  dead_time_i  in   DT_W   dead-time count D, sampled on entry to each dead state
//  fault_i      in   1      external fault, active-high
//  fault_clr_i  in   1      clear request for latched fault
//  gate_hs_o    out  NCH    high-side gate drive
//  gate_ls_o    out  NCH    low-side gate drive
//  fault_o      out  1      latched fault flag
//  irq_o        out  1      one-cycle pulse when fault latches
// BEHAVIOUR
//  - Reset (wb_rst_ni=0 at an edge): all channels IDLE; gate_hs_o, gate_ls_o, fault_o and irq_o all 0.
//  - Reset applied mid-operation takes effect at that same edge, regardless of state.
//  - Per-channel FSM states: IDLE, DT_HS, HS, DT_LS, LS.
//  - Gates are decoded from registered state only, so they are glitch-free:
//    gate_hs_o[c] = (state==HS); gate_ls_o[c] = (state==LS).
//  - Invariant: gate_hs_o[c] & gate_ls_o[c] is never 1.
//  - Transitions, with run = enable_i & ~fault_o & ~fault_now:
//    - IDLE: run & pwm_i[c] -> DT_HS; run & ~pwm_i[c] -> DT_LS.
//    - DT_HS: pwm_i[c]=0 -> DT_LS with counter reloaded; else cnt==0 -> HS; else cnt--.
//    - DT_LS: mirror image of DT_HS.
//    - HS: pwm_i[c]=0 -> DT_LS. LS: pwm_i[c]=1 -> DT_HS.
//    - Any state with ~run -> IDLE.
//  - Each dead-state entry loads cnt = dead_time_i, so a dead state lasts D+1 cycles.
//    - D=0 still gives 1 dead cycle.
//    - D=2^DT_W-1 gives 2^DT_W cycles; the counter does not wrap.
//  - Latency: pwm_i edge sampled at edge k turns the active gate off after edge k.
//    The opposite gate turns on after edge k+D+1.
//  - PWM pulses shorter than D+1 cycles never reach the gates; the channel bounces between dead states.
//  - fault_now:
//    - Without filter: fault_i=1 at an edge sets fault_o and forces all channels to IDLE at that edge.
//    - irq_o is high for exactly the cycle after fault_o rises.
//  - Clear: fault_clr_i=1 & fault_i=0 & fault_o=1 clears fault_o at that edge.
//    - Channels leave IDLE on the next edge through a dead state, never directly into HS or LS.
//    - fault_i and fault_clr_i high together: the fault wins and fault_o stays 1.
//  - enable_i=0: all channels IDLE at the next edge; fault_o is unaffected.
//  - dead_time_i changes during a dead period do not affect the running count.
// CONFIGURATION
//  - FAULT_FILTER_EN defined:
//    - A saturating counter of width $clog2(FILT_CYCLES+1) counts consecutive edges with fault_i=1.
//    - The counter resets to 0 on any edge with fault_i=0.
//    - fault_now asserts on the FILT_CYCLES-th consecutive sample; glitches shorter than that are ignored.
//  - FAULT_FILTER_EN undefined: fault_now = fault_i; FILT_CYCLES is unused.
// TESTING
//  - Dead time: D=3, pwm_i[0] 0->1 while in LS.
//    -> ls low next edge; hs high 4 cycles later; never both high.
//  - D=0 toggle every 2 cycles.
//    -> each gate high 1 cycle with a 1-cycle gap.
//    -> 1-cycle pwm pulse with D=5 never drives hs.
//  - Fault: fault_i pulse in HS (macro off).
//    -> all gates 0 and fault_o=1 after that edge; irq_o one cycle.
//    -> clear with fault_i=1 is ignored; clear with fault_i=0 restarts via DT_x.
//  - FAULT_FILTER_EN, FILT_CYCLES=4: 3-cycle fault_i glitch -> no latch.
//    4-cycle fault_i -> latch on the 4th edge.
//  - Reset: wb_rst_ni low for 1 cycle in HS with D=200 mid-count.
//    -> all outputs 0 next cycle, then normal dead-time restart.
//  - enable_i low mid-DT_HS -> IDLE with gates 0; re-enable -> full D+1 dead period before any gate.

Source files
------------

// File: rtl/pwm_deadtime_gate_stage.sv
// Complementary gate stage: one break-before-make FSM per PWM channel, plus a latched over-current fault.
// Optional macro FAULT_FILTER_EN requires FILT_CYCLES consecutive fault samples before the fault latches.
module pwm_deadtime_gate_stage #(
  parameter int NCH         = 4,
  parameter int DT_W        = 8,
  parameter int FILT_CYCLES = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            enable_i,
  input  logic [NCH-1:0]  pwm_i,
  input  logic [DT_W-1:0] dead_time_i,
  input  logic            fault_i,
  input  logic            fault_clr_i,
  output logic [NCH-1:0]  gate_hs_o,
  output logic [NCH-1:0]  gate_ls_o,
  output logic            fault_o,
  output logic            irq_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DT_HS = 3'd1,
    ST_HS    = 3'd2,
    ST_DT_LS = 3'd3,
    ST_LS    = 3'd4
  } state_e;

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [DT_W-1:0] cnt_q   [NCH];
  logic [DT_W-1:0] cnt_d   [NCH];

  logic fault_q, fault_d;
  logic irq_q, irq_d;
  logic fault_now;
  logic run;

`ifdef FAULT_FILTER_EN
  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_CYCLES);
  localparam logic [FW-1:0] FILT_THR = FW'(FILT_CYCLES - 1);

  logic [FW-1:0] filt_q, filt_d;

  // Consecutive-sample counter; the current sample completes the run when the count already sits at FILT_CYCLES-1.
  always_comb begin
    filt_d = '0;
    if (fault_i) begin
      filt_d = (filt_q == FILT_MAX) ? FILT_MAX : filt_q + 1'b1;
    end
  end

  assign fault_now = fault_i && (filt_q >= FILT_THR);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  logic unused_filt;

  assign fault_now   = fault_i;
  assign unused_filt = (FILT_CYCLES > 0);
`endif

  // A fresh fault always beats a simultaneous clear request.
  always_comb begin
    fault_d = fault_q;
    irq_d   = 1'b0;
    if (fault_now) begin
      fault_d = 1'b1;
      irq_d   = ~fault_q;
    end else if (fault_clr_i && !fault_i && fault_q) begin
      fault_d = 1'b0;
    end
  end

  assign run = enable_i & ~fault_q & ~fault_now;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (!run) begin
        state_d[c] = ST_IDLE;
      end else begin
        unique case (state_q[c])
          ST_IDLE: begin
            cnt_d[c]   = dead_time_i;
            state_d[c] = pwm_i[c] ? ST_DT_HS : ST_DT_LS;
          end
          ST_DT_HS: begin
            if (!pwm_i[c]) begin
              state_d[c] = ST_DT_LS;
              cnt_d[c]   = dead_time_i;
            end else if (cnt_q[c] == '0) begin
              state_d[c] = ST_HS;
            end else begin
              cnt_d[c] = cnt_q[c] - 1'b1;
            end
          end
          ST_HS: begin
            if (!pwm_i[c]) begin
              state_d[c] = ST_DT_LS;
              cnt_d[c]   = dead_time_i;
            end
          end
          ST_DT_LS: begin
            if (pwm_i[c]) begin
              state_d[c] = ST_DT_HS;
              cnt_d[c]   = dead_time_i;
            end else if (cnt_q[c] == '0) begin
              state_d[c] = ST_LS;
            end else begin
              cnt_d[c] = cnt_q[c] - 1'b1;
            end
          end
          ST_LS: begin
            if (pwm_i[c]) begin
              state_d[c] = ST_DT_HS;
              cnt_d[c]   = dead_time_i;
            end
          end
          default: begin
            state_d[c] = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
      fault_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      fault_q <= fault_d;
      irq_q   <= irq_d;
    end
  end

  // Gates decode straight from registered state so they cannot glitch or overlap.
  always_comb begin
    gate_hs_o = '0;
    gate_ls_o = '0;
    for (int c = 0; c < NCH; c++) begin
      gate_hs_o[c] = (state_q[c] == ST_HS);
      gate_ls_o[c] = (state_q[c] == ST_LS);
    end
  end

  assign fault_o = fault_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_pwm_deadtime_gate_stage.sv
// Bench for pwm_deadtime_gate_stage: directed scenarios plus random traffic against a dwell-time reference model.
module tb_pwm_deadtime_gate_stage;
  localparam int NCH  = 4;
  localparam int DT_W = 8;
  localparam int FILT = 4;
`ifdef FAULT_FILTER_EN
  localparam int FLT_LEN = FILT;
`else
  localparam int FLT_LEN = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [NCH-1:0]  pwm;
  logic [DT_W-1:0] dt;
  logic            fi;
  logic            fclr;
  logic [NCH-1:0]  gate_hs_o;
  logic [NCH-1:0]  gate_ls_o;
  logic            fault_o;
  logic            irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_deadtime_gate_stage #(.NCH(NCH), .DT_W(DT_W), .FILT_CYCLES(FILT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .enable_i    (en),
    .pwm_i       (pwm),
    .dead_time_i (dt),
    .fault_i     (fi),
    .fault_clr_i (fclr),
    .gate_hs_o   (gate_hs_o),
    .gate_ls_o   (gate_ls_o),
    .fault_o     (fault_o),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: a running channel drives the side pwm asks for once that request
  // has been stable for more than the dead-time value captured when the request started.
  bit             m_act [NCH];
  bit             m_des [NCH];
  int             m_el  [NCH];
  int             m_d   [NCH];
  bit             m_fault;
  bit             m_irq;
  int             m_filt;
  logic [NCH-1:0] exp_hs;
  logic [NCH-1:0] exp_ls;
  logic [2*NCH+1:0] exp_v;
  logic [2*NCH+1:0] obs_v;

  assign obs_v = {gate_hs_o, gate_ls_o, fault_o, irq_o};

  task automatic model_step();
    bit fnow;
    bit run;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) m_act[c] = 0;
      m_fault = 0;
      m_irq   = 0;
      m_filt  = 0;
    end else begin
`ifdef FAULT_FILTER_EN
      fnow   = fi && (m_filt + 1 >= FILT);
      m_filt = fi ? ((m_filt < FILT) ? m_filt + 1 : FILT) : 0;
`else
      fnow = fi;
`endif
      run   = en && !m_fault && !fnow;
      m_irq = fnow && !m_fault;
      if (fnow) m_fault = 1;
      else if (fclr && !fi) m_fault = 0;
      for (int c = 0; c < NCH; c++) begin
        if (!run) begin
          m_act[c] = 0;
        end else if (!m_act[c] || (m_des[c] != pwm[c])) begin
          m_act[c] = 1;
          m_des[c] = pwm[c];
          m_el[c]  = 0;
          m_d[c]   = int'(dt);
        end else if (m_el[c] < 100000) begin
          m_el[c]++;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      exp_hs[c] = m_act[c] && m_des[c] && (m_el[c] > m_d[c]);
      exp_ls[c] = m_act[c] && !m_des[c] && (m_el[c] > m_d[c]);
    end
    exp_v = {exp_hs, exp_ls, m_fault, m_irq};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; pwm = NCH'($urandom); dt = 8'd3; fi = 0; fclr = 0;
    repeat (3) cycle();
    n_tests++;
    if (obs_v !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", obs_v, '0);
    end
    n_tests++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL reset_model: got %b want %b", obs_v, exp_v);
    end
    rst_n = 1;
  endtask

  task automatic test_dead_time();
    en = 1; dt = 8'd3; pwm = '0;
    repeat (6) cycle();
    n_tests++;
    if (gate_ls_o !== '1 || gate_hs_o !== '0) begin
      n_fail++; $display("FAIL dt_settle_ls: got hs=%b ls=%b want hs=0000 ls=1111", gate_hs_o, gate_ls_o);
    end
    pwm[0] = 1'b1;
    cycle();
    dt = 8'd50;
    n_tests++;
    if (gate_ls_o[0] !== 1'b0 || gate_hs_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL dt_ls_off: got hs=%b ls=%b want 0 0", gate_hs_o[0], gate_ls_o[0]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (gate_hs_o[0] !== 1'b0 || (gate_hs_o & gate_ls_o) !== '0) begin
        n_fail++; $display("FAIL dt_dead_gap%0d: got hs=%b ls=%b want hs0=0", i, gate_hs_o, gate_ls_o);
      end
    end
    cycle();
    n_tests++;
    if (gate_hs_o[0] !== 1'b1 || gate_ls_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL dt_hs_on: got hs=%b ls=%b want 1 0", gate_hs_o[0], gate_ls_o[0]);
    end
    n_tests++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL dt_model: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_d0_toggle();
    int hs_cnt;
    int ls_cnt;
    dt = 8'd0; pwm = '0;
    repeat (3) cycle();
    hs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      pwm[0] = ((i % 4) < 2);
      cycle();
      hs_cnt += int'(gate_hs_o[0]);
      ls_cnt += int'(gate_ls_o[0]);
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL d0_toggle_model%0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    n_tests++;
    if (hs_cnt != 4 || ls_cnt != 4) begin
      n_fail++; $display("FAIL d0_toggle_counts: got hs=%0d ls=%0d want 4 4", hs_cnt, ls_cnt);
    end
    dt = 8'd5; pwm = '0;
    repeat (8) cycle();
    for (int i = 0; i < 24; i++) begin
      pwm[0] = ((i % 4) == 0);
      cycle();
      n_tests++;
      if (gate_hs_o[0] !== 1'b0 || obs_v !== exp_v) begin
        n_fail++; $display("FAIL short_pulse%0d: got %b want %b (hs0 must stay 0)", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_fault();
    dt = 8'd2; pwm = '1; fi = 0; fclr = 0;
    repeat (6) cycle();
    n_tests++;
    if (gate_hs_o !== '1) begin
      n_fail++; $display("FAIL fault_pre_hs: got %b want 1111", gate_hs_o);
    end
    fi = 1;
    for (int i = 1; i < FLT_LEN; i++) cycle();
    cycle();
    n_tests++;
    if (gate_hs_o !== '0 || gate_ls_o !== '0 || fault_o !== 1'b1 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL fault_latch: got %b want %b", obs_v, {{(2*NCH){1'b0}}, 2'b11});
    end
    fi = 0;
    cycle();
    n_tests++;
    if (obs_v !== {{(2*NCH){1'b0}}, 2'b10}) begin
      n_fail++; $display("FAIL fault_irq_one: got %b want %b", obs_v, {{(2*NCH){1'b0}}, 2'b10});
    end
    fi = 1; fclr = 1;
    cycle();
    n_tests++;
    if (fault_o !== 1'b1 || irq_o !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL fault_clr_blocked: got %b want %b", obs_v, exp_v);
    end
    fi = 0;
    cycle();
    fclr = 0;
    n_tests++;
    if (fault_o !== 1'b0 || gate_hs_o !== '0) begin
      n_fail++; $display("FAIL fault_cleared: got fault=%b hs=%b want 0 0000", fault_o, gate_hs_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (gate_hs_o !== '0 || gate_ls_o !== '0) begin
        n_fail++; $display("FAIL fault_restart_dead%0d: got hs=%b ls=%b want 0", i, gate_hs_o, gate_ls_o);
      end
    end
    cycle();
    n_tests++;
    if (gate_hs_o !== '1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL fault_restart_hs: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_filter();
`ifdef FAULT_FILTER_EN
    fi = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (fault_o !== 1'b0 || obs_v !== exp_v) begin
        n_fail++; $display("FAIL filt_glitch%0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    fi = 0;
    cycle();
    fi = 1;
    for (int i = 0; i < 3; i++) cycle();
    n_tests++;
    if (fault_o !== 1'b0) begin
      n_fail++; $display("FAIL filt_pre_latch: got %b want 0", fault_o);
    end
    cycle();
    n_tests++;
    if (fault_o !== 1'b1 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL filt_latch4: got fault=%b irq=%b want 1 1", fault_o, irq_o);
    end
`else
    fi = 1;
    cycle();
    n_tests++;
    if (fault_o !== 1'b1 || irq_o !== 1'b1 || gate_hs_o !== '0) begin
      n_fail++; $display("FAIL nofilt_latch1: got %b want %b", obs_v, exp_v);
    end
`endif
    fi = 0; fclr = 1;
    cycle();
    fclr = 0;
    n_tests++;
    if (fault_o !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL filt_clear: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_enable();
    dt = 8'd4; pwm = '0; en = 1;
    repeat (8) cycle();
    n_tests++;
    if (gate_ls_o !== '1) begin
      n_fail++; $display("FAIL en_pre_ls: got %b want 1111", gate_ls_o);
    end
    pwm = '1;
    repeat (2) cycle();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (gate_hs_o !== '0 || gate_ls_o !== '0 || obs_v !== exp_v) begin
        n_fail++; $display("FAIL en_off%0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    en = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++;
      if (gate_hs_o !== '0) begin
        n_fail++; $display("FAIL en_dead%0d: got hs=%b want 0000", i, gate_hs_o);
      end
    end
    cycle();
    n_tests++;
    if (gate_hs_o !== '1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL en_hs_on: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    dt = 8'd2; pwm = '1;
    repeat (5) cycle();
    dt = 8'd200;
    pwm[1] = 1'b0;
    repeat (10) cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    n_tests++;
    if (obs_v !== '0) begin
      n_fail++; $display("FAIL rstmid_zero: got %b want 0", obs_v);
    end
    for (int i = 0; i < 201; i++) begin
      cycle();
      n_tests++;
      if (gate_hs_o !== '0 || gate_ls_o !== '0 || obs_v !== exp_v) begin
        n_fail++; $display("FAIL rstmid_dead%0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    cycle();
    n_tests++;
    if (gate_hs_o !== 4'b1101 || gate_ls_o !== 4'b0010) begin
      n_fail++; $display("FAIL rstmid_on: got hs=%b ls=%b want 1101 0010", gate_hs_o, gate_ls_o);
    end
  endtask

  task automatic test_max_dead();
    en = 0;
    cycle();
    dt = 8'd255; pwm = NCH'($urandom); en = 1;
    for (int i = 0; i < 256; i++) begin
      cycle();
      n_tests++;
      if (gate_hs_o !== '0 || gate_ls_o !== '0) begin
        n_fail++; $display("FAIL maxdead%0d: got hs=%b ls=%b want 0", i, gate_hs_o, gate_ls_o);
      end
    end
    cycle();
    n_tests++;
    if (gate_hs_o !== pwm || gate_ls_o !== ~pwm) begin
      n_fail++; $display("FAIL maxdead_on: got hs=%b ls=%b want %b %b", gate_hs_o, gate_ls_o, pwm, ~pwm);
    end
  endtask

  task automatic test_random();
    int fi_left;
    fi_left = 0;
    for (int i = 0; i < 3000; i++) begin
      pwm   = pwm ^ (NCH'($urandom) & NCH'($urandom) & NCH'($urandom));
      if ($urandom_range(0, 9) == 0) dt = DT_W'($urandom_range(0, 6));
      en    = ($urandom_range(0, 59) != 0);
      if (fi_left == 0 && $urandom_range(0, 79) == 0) fi_left = $urandom_range(1, 6);
      fi    = (fi_left > 0);
      if (fi_left > 0) fi_left--;
      fclr  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cycle();
      n_tests++;
      if (obs_v !== exp_v || (gate_hs_o & gate_ls_o) !== '0) begin
        n_fail++; $display("FAIL random%0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    rst_n = 1; fi = 0; fclr = 0;
  endtask

  initial begin
    rst_n = 0; en = 0; pwm = '0; dt = '0; fi = 0; fclr = 0;
    test_reset();
    test_dead_time();
    test_d0_toggle();
    test_fault();
    test_filter();
    test_enable();
    test_reset_mid();
    test_max_dead();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
